mcu_el2_lsu_trigger_ctl: RTL and testbench
==========================================

MCU_EL2_LSU_TRIGGER_CTL -- requirements
Module: mcu_el2_lsu_trigger_ctl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port csr_wr_valid, input, 1: CSR write request.
REQ-004 SHALL have port csr_wr_ready, output, 1: CSR write accepted when high with csr_wr_valid.
REQ-005 SHALL have port csr_wr_idx, input, 2: trigger index 0-3.
REQ-006 SHALL have port csr_wr_sel, input, 1: target register, 0=tdata1, 1=tdata2.
REQ-007 SHALL have port csr_wr_data, input, 32: write data.
REQ-008 SHALL have port dbg_mode, input, 1: core is in debug mode.
REQ-009 SHALL have port lsu_valid_m, input, 1: M-stage LSU op valid.
REQ-010 SHALL have port flush_m, input, 1: kill the M-stage op.
REQ-011 SHALL have port lsu_trigger_match_m, input, 4: raw per-trigger match from the LSU trigger datapath.
REQ-012 SHALL have ports trig_m, trig_load, trig_store, trig_select, trig_match, output, 4 each: per-trigger config fields driven to the datapath.
REQ-013 SHALL have port trig_tdata2, output, 128: tdata2 of trigger i at bits [32i+31:32i].
REQ-014 SHALL have port trig_hit, output, 4: tdata1 hit bits.
REQ-015 SHALL have ports trig_action_req (output, 1), trig_action_halt (output, 1; 1=debug halt, 0=breakpoint exception), trig_action_ack (input, 1).
REQ-016 SHALL have port trig_missed_cnt, output, 8: saturating count of dropped fires.

Function
REQ-017 SHALL hold per-trigger tdata1 fields: bit0 load, bit1 store, bit6 m, bit7 match, bit11 chain (triggers 0, 2 only; forced 0 on 1, 3), bit12 action, bit19 select, bit20 hit, bit27 dmode; all other bits read as 0 and are not stored.
REQ-018 SHALL drive trig_* outputs directly from registered state; config writes take effect the cycle after acceptance.
REQ-019 SHALL ignore (accept, no state change) a write to trigger i when its dmode=1 and dbg_mode=0; a dmode=1 write from dbg_mode=0 SHALL store dmode=0.
REQ-020 SHALL compute fire[i] = lsu_valid_m & ~flush_m & lsu_trigger_match_m[i] & trig_m[i], with chaining: if chain[k]=1 (k in {0,2}), fire[k] and fire[k+1] SHALL each require both raw fires of k and k+1, otherwise neither fires.
REQ-021 SHALL use a 2-state FSM, IDLE and REQ.
REQ-022 IDLE: any fire in cycle N SHALL set the fired hit bits and enter REQ with trig_action_req=1 in cycle N+1.
REQ-023 trig_action_halt SHALL be registered with the request: 1 if any fired trigger has action=1, else 0; held stable throughout REQ.
REQ-024 REQ: trig_action_req SHALL stay high until trig_action_ack is sampled high, then return to IDLE the next cycle; an ack in IDLE SHALL be ignored.
REQ-025 Fires during REQ SHALL NOT set hit bits and SHALL increment trig_missed_cnt by 1, saturating at 255.
REQ-026 csr_wr_ready SHALL be 1 in IDLE and 0 in REQ.
REQ-027 Write to tdata1 and fire on the same trigger in the same cycle: written fields SHALL be stored and hit SHALL read 1 next cycle; fire evaluation SHALL use pre-write config.
REQ-028 Hit bits SHALL clear only via a tdata1 write with bit20=0.

Reset
REQ-029 On rst: all tdata1/tdata2 state 0, trig_hit 0, trig_action_req 0, trig_action_halt 0, trig_missed_cnt 0, FSM IDLE, csr_wr_ready 1 the cycle after rst deasserts.
REQ-030 rst asserted in REQ SHALL abandon the request with no ack required.

Verification
REQ-031 Write tdata2[0]=0x8000_0040, tdata1[0]=0x0000_0043; raw match[0] with lsu_valid_m -> next cycle trig_hit=0001, req=1, halt=0; ack -> req=0 following cycle.
REQ-032 tdata1[0] chain=1, tdata1[1] m=1; raw match=0001 -> no fire; raw match=0011 -> trig_hit=0011, req=1.
REQ-033 In REQ, three further fires -> trig_missed_cnt=3, trig_hit unchanged, csr_wr_ready=0.
REQ-034 Triggers 2 (action=0) and 3 (action=1) fire together -> trig_hit=1100, halt=1.
REQ-035 Trigger 1 dmode=1 written in dbg_mode; write 0x0 outside dbg_mode -> config unchanged; flush_m with match -> no fire.
REQ-036 rst mid-REQ -> req=0, all outputs 0 next cycle.

Source files
------------

// File: rtl/mcu_el2_lsu_trigger_ctl.sv
// mcu_el2_lsu_trigger_ctl
//   Control side of four LSU debug triggers: holds the per-trigger tdata1/tdata2
//   configuration, qualifies the raw datapath matches (including pairwise
//   chaining 0+1 and 2+3), records hit bits and raises a single action request
//   that is held until acknowledged. Fires that arrive while a request is
//   outstanding are dropped and counted.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   csr_wr_*                  CSR write channel (idx = trigger, sel 0=tdata1 1=tdata2)
//   dbg_mode                  core is in debug mode (gates dmode-protected triggers)
//   lsu_valid_m, flush_m      M-stage op qualifiers
//   lsu_trigger_match_m       raw per-trigger match from the datapath
//   trig_m/load/store/select/match, trig_tdata2   config driven to the datapath
//   trig_hit                  tdata1 hit bits
//   trig_action_req/halt/ack  action handshake (halt=1 debug halt, 0 breakpoint)
//   trig_missed_cnt           saturating count of fires dropped during a request
//
// State | meaning
// IDLE  | no request outstanding, CSR writes accepted, fires recorded as hits
// REQ   | action request raised, waiting for ack; fires counted as missed

module mcu_el2_lsu_trigger_ctl (
  input  logic         clk,
  input  logic         rst,
  input  logic         csr_wr_valid,
  output logic         csr_wr_ready,
  input  logic [1:0]   csr_wr_idx,
  input  logic         csr_wr_sel,
  input  logic [31:0]  csr_wr_data,
  input  logic         dbg_mode,
  input  logic         lsu_valid_m,
  input  logic         flush_m,
  input  logic [3:0]   lsu_trigger_match_m,
  output logic [3:0]   trig_m,
  output logic [3:0]   trig_load,
  output logic [3:0]   trig_store,
  output logic [3:0]   trig_select,
  output logic [3:0]   trig_match,
  output logic [127:0] trig_tdata2,
  output logic [3:0]   trig_hit,
  output logic         trig_action_req,
  output logic         trig_action_halt,
  input  logic         trig_action_ack,
  output logic [7:0]   trig_missed_cnt
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state, state_nxt;
  logic [1:0]  chain_q;       // [0] = trigger 0, [1] = trigger 2
  logic [3:0]  action_q;
  logic [3:0]  dmode_q;
  logic [3:0]  wr_dec;
  logic        wr_blocked;
  logic        wr_en;
  logic [3:0]  wr_t1;
  logic [3:0]  wr_t2;
  logic [3:0]  raw_fire;
  logic [3:0]  fire;
  logic [3:0]  hit_set;
  logic        any_fire;
  logic        unused_data;

  assign csr_wr_ready    = (state == IDLE);
  assign trig_action_req = (state == REQ);

  // A write to a dmode-owned trigger from outside debug mode is accepted
  // on the handshake but leaves the trigger untouched.
  assign wr_dec     = 4'b0001 << csr_wr_idx;
  assign wr_blocked = dmode_q[csr_wr_idx] & ~dbg_mode;
  assign wr_en      = csr_wr_valid & csr_wr_ready & ~wr_blocked;
  assign wr_t1      = {4{wr_en & ~csr_wr_sel}} & wr_dec;
  assign wr_t2      = {4{wr_en &  csr_wr_sel}} & wr_dec;

  // Fire qualification uses the config as it stands before any same-cycle write.
  assign raw_fire = {4{lsu_valid_m & ~flush_m}} & lsu_trigger_match_m & trig_m;

  always_comb begin
    fire = raw_fire;
    if (chain_q[0]) fire[1:0] = {2{&raw_fire[1:0]}};
    if (chain_q[1]) fire[3:2] = {2{&raw_fire[3:2]}};
  end

  assign any_fire = |fire;
  assign hit_set  = (state == IDLE) ? fire : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_load   <= '0;
      trig_store  <= '0;
      trig_m      <= '0;
      trig_match  <= '0;
      trig_select <= '0;
      trig_hit    <= '0;
      action_q    <= '0;
      dmode_q     <= '0;
      chain_q     <= '0;
      trig_tdata2 <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_t1[i]) begin
          trig_load[i]   <= csr_wr_data[0];
          trig_store[i]  <= csr_wr_data[1];
          trig_m[i]      <= csr_wr_data[6];
          trig_match[i]  <= csr_wr_data[7];
          action_q[i]    <= csr_wr_data[12];
          trig_select[i] <= csr_wr_data[19];
          dmode_q[i]     <= csr_wr_data[27] & dbg_mode;
          // a same-cycle fire wins over a written hit=0
          trig_hit[i]    <= csr_wr_data[20] | hit_set[i];
        end else if (hit_set[i]) begin
          trig_hit[i]    <= 1'b1;
        end
        if (wr_t2[i]) trig_tdata2[32*i +: 32] <= csr_wr_data;
      end
      if (wr_t1[0]) chain_q[0] <= csr_wr_data[11];
      if (wr_t1[2]) chain_q[1] <= csr_wr_data[11];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_fire)        state_nxt = REQ;
      REQ:     if (trig_action_ack) state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_action_halt <= 1'b0;
      trig_missed_cnt  <= '0;
    end else begin
      if (state == IDLE && any_fire)
        trig_action_halt <= |(fire & action_q);
      else if (state == REQ && trig_action_ack)
        trig_action_halt <= 1'b0;
      if (state == REQ && any_fire && trig_missed_cnt != 8'hFF)
        trig_missed_cnt <= trig_missed_cnt + 8'd1;
    end
  end

  assign unused_data = ^{csr_wr_data[31:28], csr_wr_data[26:21], csr_wr_data[18:13],
                         csr_wr_data[10:8], csr_wr_data[5:2]};

endmodule

// File: tb/tb_mcu_el2_lsu_trigger_ctl.sv
module tb_mcu_el2_lsu_trigger_ctl;

  logic         clk;
  logic         rst;
  logic         csr_wr_valid;
  logic         csr_wr_ready;
  logic [1:0]   csr_wr_idx;
  logic         csr_wr_sel;
  logic [31:0]  csr_wr_data;
  logic         dbg_mode;
  logic         lsu_valid_m;
  logic         flush_m;
  logic [3:0]   lsu_trigger_match_m;
  logic [3:0]   trig_m, trig_load, trig_store, trig_select, trig_match;
  logic [127:0] trig_tdata2;
  logic [3:0]   trig_hit;
  logic         trig_action_req;
  logic         trig_action_halt;
  logic         trig_action_ack;
  logic [7:0]   trig_missed_cnt;

  int tests;
  int failed;

  mcu_el2_lsu_trigger_ctl dut (
    .clk(clk), .rst(rst),
    .csr_wr_valid(csr_wr_valid), .csr_wr_ready(csr_wr_ready),
    .csr_wr_idx(csr_wr_idx), .csr_wr_sel(csr_wr_sel), .csr_wr_data(csr_wr_data),
    .dbg_mode(dbg_mode), .lsu_valid_m(lsu_valid_m), .flush_m(flush_m),
    .lsu_trigger_match_m(lsu_trigger_match_m),
    .trig_m(trig_m), .trig_load(trig_load), .trig_store(trig_store),
    .trig_select(trig_select), .trig_match(trig_match),
    .trig_tdata2(trig_tdata2), .trig_hit(trig_hit),
    .trig_action_req(trig_action_req), .trig_action_halt(trig_action_halt),
    .trig_action_ack(trig_action_ack), .trig_missed_cnt(trig_missed_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wv;
    logic [1:0]  idx;
    logic        sel;
    logic [31:0] data;
    logic        dbg;
    logic        v;
    logic        fl;
    logic [3:0]  mt;
    logic        ack;
    logic [3:0]  e_hit;
    logic        e_req;
    logic        e_halt;
    logic        e_rdy;
    logic [7:0]  e_missed;
    logic [3:0]  e_m;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic wv, logic [1:0] idx, logic sel, logic [31:0] d,
                              logic dbg, logic v, logic fl, logic [3:0] mt, logic ack,
                              logic [3:0] eh, logic erq, logic eha, logic erd,
                              logic [7:0] emi, logic [3:0] em);
    vec_t t;
    t.rst = r; t.wv = wv; t.idx = idx; t.sel = sel; t.data = d; t.dbg = dbg;
    t.v = v; t.fl = fl; t.mt = mt; t.ack = ack;
    t.e_hit = eh; t.e_req = erq; t.e_halt = eha; t.e_rdy = erd; t.e_missed = emi; t.e_m = em;
    return t;
  endfunction

  task automatic chk(string nm, logic [199:0] act, logic [199:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; csr_wr_valid = 1'b0; csr_wr_idx = 2'd0; csr_wr_sel = 1'b0;
    csr_wr_data = 32'h0; dbg_mode = 1'b0; lsu_valid_m = 1'b0; flush_m = 1'b0;
    lsu_trigger_match_m = 4'h0; trig_action_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] idx, logic sel, logic [31:0] d, logic dbg);
    idle_inputs();
    csr_wr_valid = 1'b1; csr_wr_idx = idx; csr_wr_sel = sel; csr_wr_data = d; dbg_mode = dbg;
    tick();
  endtask

  // Reference model: architectural tdata1/tdata2 words plus request state.
  localparam logic [31:0] MASK_EVEN = 32'h0818_18C3;
  localparam logic [31:0] MASK_ODD  = 32'h0818_10C3;
  logic [31:0] mt1 [4];
  logic [31:0] mt2 [4];
  logic        mreq, mhalt;
  logic [7:0]  mmissed;

  task automatic model_step();
    logic [3:0]  raw, f, act;
    logic [31:0] w;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin mt1[i] = 0; mt2[i] = 0; end
      mreq = 0; mhalt = 0; mmissed = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      raw[i] = lsu_valid_m && !flush_m && lsu_trigger_match_m[i] && mt1[i][6];
      act[i] = mt1[i][12];
    end
    f = raw;
    for (int k = 0; k < 4; k += 2)
      if (mt1[k][11]) begin
        f[k]   = raw[k] && raw[k+1];
        f[k+1] = raw[k] && raw[k+1];
      end
    if (!mreq) begin
      if (csr_wr_valid && !(mt1[csr_wr_idx][27] && !dbg_mode)) begin
        if (csr_wr_sel) mt2[csr_wr_idx] = csr_wr_data;
        else begin
          w = csr_wr_data & (csr_wr_idx[0] ? MASK_ODD : MASK_EVEN);
          if (!dbg_mode) w[27] = 1'b0;
          mt1[csr_wr_idx] = w;
        end
      end
      for (int i = 0; i < 4; i++) if (f[i]) mt1[i][20] = 1'b1;
      if (f != 0) begin mreq = 1; mhalt = |(f & act); end
    end else begin
      if (f != 0 && mmissed < 8'd255) mmissed = mmissed + 8'd1;
      if (trig_action_ack) begin mreq = 0; mhalt = 0; end
    end
  endtask

  function automatic logic [162:0] model_vec();
    logic [3:0] m, l, s, se, ma, h;
    for (int i = 0; i < 4; i++) begin
      m[i] = mt1[i][6]; l[i] = mt1[i][0]; s[i] = mt1[i][1];
      se[i] = mt1[i][19]; ma[i] = mt1[i][7]; h[i] = mt1[i][20];
    end
    return {m, l, s, se, ma, h, mt2[3], mt2[2], mt2[1], mt2[0], mreq, mhalt, !mreq, mmissed};
  endfunction

  function automatic logic [162:0] dut_vec();
    return {trig_m, trig_load, trig_store, trig_select, trig_match, trig_hit, trig_tdata2,
            trig_action_req, trig_action_halt, csr_wr_ready, trig_missed_cnt};
  endfunction

  initial begin
    tests = 0;
    failed = 0;
    idle_inputs();
    rst = 1'b1;
    #2;

    //            rst wv idx sel data          dbg v fl mt    ack | hit  req halt rdy missed m
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 4'h0, 0,  4'h0, 0, 0, 1, 8'd0, 4'h0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h8000_0040,0, 0, 0, 4'h0, 0,  4'h0, 0, 0, 1, 8'd0, 4'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h43,       0, 0, 0, 4'h0, 0,  4'h0, 0, 0, 1, 8'd0, 4'h1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 4'h1, 0,  4'h1, 1, 0, 0, 8'd0, 4'h1));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 4'h0, 1,  4'h1, 0, 0, 1, 8'd0, 4'h1));
    tbl.push_back(mk(0, 1, 0, 0, 32'h843,      0, 0, 0, 4'h0, 0,  4'h0, 0, 0, 1, 8'd0, 4'h1));
    tbl.push_back(mk(0, 1, 1, 0, 32'h43,       0, 0, 0, 4'h0, 0,  4'h0, 0, 0, 1, 8'd0, 4'h3));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 4'h1, 0,  4'h0, 0, 0, 1, 8'd0, 4'h3));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 4'h3, 0,  4'h3, 1, 0, 0, 8'd0, 4'h3));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 4'h3, 0,  4'h3, 1, 0, 0, 8'd1, 4'h3));
    tbl.push_back(mk(0, 1, 2, 0, 32'h43,       0, 1, 0, 4'h3, 0,  4'h3, 1, 0, 0, 8'd2, 4'h3));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 4'h3, 0,  4'h3, 1, 0, 0, 8'd3, 4'h3));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 4'h0, 1,  4'h3, 0, 0, 1, 8'd3, 4'h3));
    tbl.push_back(mk(0, 1, 2, 0, 32'h43,       0, 0, 0, 4'h0, 0,  4'h3, 0, 0, 1, 8'd3, 4'h7));
    tbl.push_back(mk(0, 1, 3, 0, 32'h1043,     0, 0, 0, 4'h0, 0,  4'h3, 0, 0, 1, 8'd3, 4'hF));
    tbl.push_back(mk(0, 1, 0, 0, 32'h843,      0, 0, 0, 4'h0, 0,  4'h2, 0, 0, 1, 8'd3, 4'hF));
    tbl.push_back(mk(0, 1, 1, 0, 32'h43,       0, 0, 0, 4'h0, 0,  4'h0, 0, 0, 1, 8'd3, 4'hF));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 4'hC, 0,  4'hC, 1, 1, 0, 8'd3, 4'hF));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 4'hF, 1,  4'hC, 0, 0, 1, 8'd4, 4'hF));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 4'h0, 1,  4'hC, 0, 0, 1, 8'd4, 4'hF));
    tbl.push_back(mk(0, 1, 2, 0, 32'h0,        0, 1, 0, 4'h4, 0,  4'hC, 1, 0, 0, 8'd4, 4'hB));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 4'h0, 1,  4'hC, 0, 0, 1, 8'd4, 4'hB));

    foreach (tbl[n]) begin
      rst = tbl[n].rst; csr_wr_valid = tbl[n].wv; csr_wr_idx = tbl[n].idx;
      csr_wr_sel = tbl[n].sel; csr_wr_data = tbl[n].data; dbg_mode = tbl[n].dbg;
      lsu_valid_m = tbl[n].v; flush_m = tbl[n].fl; lsu_trigger_match_m = tbl[n].mt;
      trig_action_ack = tbl[n].ack;
      tick();
      chk($sformatf("vec%0d", n),
          {trig_hit, trig_action_req, trig_action_halt, csr_wr_ready, trig_missed_cnt, trig_m},
          {tbl[n].e_hit, tbl[n].e_req, tbl[n].e_halt, tbl[n].e_rdy, tbl[n].e_missed, tbl[n].e_m});
    end
    chk("tdata2_0", trig_tdata2[31:0], 32'h8000_0040);

    // dmode protection
    wr(2'd1, 1'b0, 32'h0800_0043, 1'b1);
    chk("dmode_set", {trig_m, trig_load}, {4'hB, 4'hB});
    wr(2'd1, 1'b0, 32'h0, 1'b0);
    chk("dmode_block_t1", {trig_m, trig_load}, {4'hB, 4'hB});
    wr(2'd1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("dmode_block_t2", trig_tdata2[63:32], 32'h0);
    idle_inputs(); lsu_valid_m = 1'b1; flush_m = 1'b1; lsu_trigger_match_m = 4'h3;
    tick();
    chk("flush_nofire", {trig_hit, trig_action_req}, {4'hC, 1'b0});
    wr(2'd0, 1'b0, 32'h0800_0003, 1'b0);
    chk("dmode_dropped", trig_m, 4'hA);
    wr(2'd0, 1'b0, 32'h843, 1'b0);
    chk("dmode0_writable", trig_m, 4'hB);

    // chained fire, then saturate the missed counter
    idle_inputs(); lsu_valid_m = 1'b1; lsu_trigger_match_m = 4'h3;
    tick();
    chk("chain_fire", {trig_hit, trig_action_req, trig_action_halt, csr_wr_ready}, {4'hF, 1'b1, 1'b0, 1'b0});
    for (int c = 0; c < 250; c++) tick();
    chk("missed_254", trig_missed_cnt, 8'd254);
    for (int c = 0; c < 10; c++) tick();
    chk("missed_sat", {trig_missed_cnt, trig_action_req, csr_wr_ready}, {8'd255, 1'b1, 1'b0});

    // reset in the middle of a request
    idle_inputs(); rst = 1'b1;
    tick();
    chk("rst_midreq", {trig_hit, trig_action_req, trig_action_halt, trig_missed_cnt, trig_m,
                       trig_load, trig_store, trig_tdata2, csr_wr_ready}, {1'b1});
    idle_inputs();
    tick();
    chk("rst_release", {trig_action_req, csr_wr_ready}, {1'b0, 1'b1});

    // randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(299) == 0);
      csr_wr_valid = ($urandom_range(2) == 0);
      csr_wr_idx = 2'($urandom_range(3));
      csr_wr_sel = 1'($urandom_range(1));
      csr_wr_data = $urandom;
      dbg_mode = ($urandom_range(3) == 0);
      lsu_valid_m = ($urandom_range(3) != 0);
      flush_m = ($urandom_range(7) == 0);
      lsu_trigger_match_m = 4'($urandom_range(15));
      trig_action_ack = ($urandom_range(3) == 0);
      #1;
      model_step();
      tick();
      chk($sformatf("rand%0d", c), dut_vec(), model_vec());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
